// File: rtl/regfile_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter_if
//
// Bundles every non-clock signal of regfile_read_arbiter: the per-requester
// request/response handshakes and the shared register-file read port.
//
// Modports
//   slave  : the arbiter. Takes requests and read data; drives grants, the read
//            select and the responses.
//   master : the surrounding core (requesters plus the register-file read mux).
//
// Signals
//   req_valid    [NUM_REQ]           per-requester read request
//   req_addr     [NUM_REQ][ADDR_W]   per-requester register number
//   req_ready    [NUM_REQ]           one-hot grant, request accepted this cycle
//   rf_read_reg  [ADDR_W]            registered select into the read mux
//   rf_read_data [DATA_W]            read mux output
//   rsp_valid    [NUM_REQ]           one-hot, response belongs to that requester
//   rsp_data     [DATA_W]            captured register value
//   rsp_ready    [NUM_REQ]           requester accepts its response
// -----------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]             req_ready;
    logic [ADDR_W-1:0]              rf_read_reg;
    logic [DATA_W-1:0]              rf_read_data;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_data;
    logic [NUM_REQ-1:0]             rsp_ready;

    modport slave (
        input  req_valid, req_addr, rf_read_data, rsp_ready,
        output req_ready, rf_read_reg, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_addr, rf_read_data, rsp_ready,
        input  req_ready, rf_read_reg, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//
// Shares one register-file read port between NUM_REQ requesters (decode,
// store-data, debug, ...) using round-robin arbitration. Each read runs as
// grant -> drive select (READ) -> capture data -> hold response (RESP) until the
// owning requester accepts it. A handshake in RESP can accept the next winner in
// the same cycle, giving one read every two cycles under continuous load.
//
// Ports
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high reset
//   bus    regfile_read_arbiter_if.slave (requests, responses, read port)
//
// Configuration
//   ZERO_REG_BYPASS_EN  when defined, a read of register 31 (XZR) skips READ,
//                       returns zero one cycle after accept and leaves
//                       rf_read_reg untouched. Undefined: every address,
//                       including 31, is read through the mux.
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_read_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [PTR_W-1:0]   rr_ptr;       // last winner; search starts just above it
    logic [PTR_W-1:0]   owner;        // requester whose read is in flight
    logic [ADDR_W-1:0]  read_reg_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               arb_en;
    logic               owner_ack;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               win_bypass;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at rr_ptr+1, rr_ptr+2, ...
    // wrapping mod NUM_REQ. The current pointer is visited last, so a
    // requester that keeps req_valid high yields to everyone else first.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && bus.req_valid[PTR_W'((int'(rr_ptr) + i) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // A new request may only be taken when the port is free: in IDLE, or in
    // the RESP cycle where the owner accepts its response. rsp_ready from
    // non-owners never opens the window.
    assign owner_ack = (state == RESP) && bus.rsp_ready[owner];
    assign arb_en    = (state == IDLE) || owner_ack;
    assign grant     = (arb_en && win_found && !reset) ? (NUM_REQ'(1) << win_idx) : '0;
    assign accept    = |grant;

`ifdef ZERO_REG_BYPASS_EN
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);
    assign win_bypass = (bus.req_addr[win_idx] == ZERO_REG);
`else
    assign win_bypass = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = win_bypass ? RESP : READ;
                end
            end
            READ: begin
                state_next = RESP;
            end
            RESP: begin
                if (accept) begin
                    state_next = win_bypass ? RESP : READ;
                end else if (owner_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Later assignments win: an accept in the handshake cycle
    // overrides the rsp_valid clear when the new winner is bypassed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            read_reg_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            owner       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            if (owner_ack) begin
                rsp_valid_q <= '0;
            end

            if (state == READ) begin
                rsp_data_q  <= bus.rf_read_data;
                rsp_valid_q <= NUM_REQ'(1) << owner;
            end

            if (accept) begin
                owner  <= win_idx;
                rr_ptr <= win_idx;
                if (win_bypass) begin
                    rsp_data_q  <= '0;
                    rsp_valid_q <= grant;
                end else begin
                    read_reg_q <= bus.req_addr[win_idx];
                end
            end
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rf_read_reg = read_reg_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_arbiter
//
// Directed bench for regfile_read_arbiter (4 requesters, 64-bit data). The
// register-file read mux is modelled as a pure function of rf_read_reg:
// X31 reads zero, register n reads 64'hDEAD_BEEF_0000_0000 | n.
// Inputs are driven 1 time unit after each rising edge; outputs are compared
// there, away from the edge. Define ZERO_REG_BYPASS_EN for both bench and RTL
// to exercise the bypass build.
// -----------------------------------------------------------------------------
module tb_regfile_read_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] reg_value(input logic [ADDR_W-1:0] a);
        return (a == 5'd31) ? 64'd0 : {32'hDEAD_BEEF, 27'd0, a};
    endfunction

    assign bus.rf_read_data = reg_value(bus.rf_read_reg);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = '0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_rsp_valid: got %b expected %b", bus.rsp_valid, 4'b0000);
        end
        checks++;
        if (bus.rsp_data !== 64'd0) begin
            errors++; $display("FAIL reset_rsp_data: got %h expected %h", bus.rsp_data, 64'd0);
        end
        checks++;
        if (bus.rf_read_reg !== 5'd0) begin
            errors++; $display("FAIL reset_rf_read_reg: got %0d expected %0d", bus.rf_read_reg, 0);
        end
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready: got %b expected %b", bus.req_ready, 4'b0000);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        bus.req_addr[0] = 5'd5;
        bus.req_valid   = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant: got %b expected %b", bus.req_ready, 4'b0001);
        end
        step();
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.rf_read_reg !== 5'd5) begin
            errors++; $display("FAIL single_select: got %0d expected %0d", bus.rf_read_reg, 5);
        end
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL single_early_rsp: got %b expected %b", bus.rsp_valid, 4'b0000);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 4'b0001) begin
            errors++; $display("FAIL single_rsp_valid: got %b expected %b", bus.rsp_valid, 4'b0001);
        end
        checks++;
        if (bus.rsp_data !== 64'hDEAD_BEEF_0000_0005) begin
            errors++; $display("FAIL single_rsp_data: got %h expected %h", bus.rsp_data, 64'hDEAD_BEEF_0000_0005);
        end
        bus.rsp_ready = 4'b0001;
        step();
        bus.rsp_ready = '0;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL single_rsp_clear: got %b expected %b", bus.rsp_valid, 4'b0000);
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] exp_oh;
        int                 w;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i] = ADDR_W'(i + 1);
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        #1;
        // Expected grant order after reset: 0,1,2,3,0 with a grant every 2 cycles.
        for (int k = 0; k < 5; k++) begin
            w      = k % NUM_REQ;
            exp_oh = 4'b0001 << w;
            checks++;
            if (bus.req_ready !== exp_oh) begin
                errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_oh);
            end
            step();
            checks++;
            if (bus.rf_read_reg !== ADDR_W'(w + 1)) begin
                errors++; $display("FAIL b2b_select[%0d]: got %0d expected %0d", k, bus.rf_read_reg, w + 1);
            end
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                errors++; $display("FAIL b2b_read_grant[%0d]: got %b expected %b", k, bus.req_ready, 4'b0000);
            end
            step();
            checks++;
            if (bus.rsp_valid !== exp_oh) begin
                errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b expected %b", k, bus.rsp_valid, exp_oh);
            end
            checks++;
            if (bus.rsp_data !== reg_value(ADDR_W'(w + 1))) begin
                errors++; $display("FAIL b2b_rsp_data[%0d]: got %h expected %h", k, bus.rsp_data, reg_value(ADDR_W'(w + 1)));
            end
        end
        bus.req_valid = '0;
        step();
        bus.rsp_ready = '0;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL b2b_drain: got %b expected %b", bus.rsp_valid, 4'b0000);
        end
    endtask

    // Owner stalls its response; non-owners raise rsp_ready part-way through.
    task automatic test_hold_and_non_owner();
        apply_reset();
        bus.req_addr[0] = 5'd7;
        bus.req_valid   = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL hold_grant: got %b expected %b", bus.req_ready, 4'b0001);
        end
        step();
        bus.req_addr[1] = 5'd8;
        bus.req_addr[2] = 5'd9;
        bus.req_valid   = 4'b0110;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL hold_read_grant: got %b expected %b", bus.req_ready, 4'b0000);
        end
        step();
        for (int c = 0; c < 6; c++) begin
            bus.rsp_ready = (c >= 2) ? 4'b0110 : 4'b0000;
            #1;
            checks++;
            if (bus.rsp_valid !== 4'b0001) begin
                errors++; $display("FAIL hold_rsp_valid[%0d]: got %b expected %b", c, bus.rsp_valid, 4'b0001);
            end
            checks++;
            if (bus.rsp_data !== 64'hDEAD_BEEF_0000_0007) begin
                errors++; $display("FAIL hold_rsp_data[%0d]: got %h expected %h", c, bus.rsp_data, 64'hDEAD_BEEF_0000_0007);
            end
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                errors++; $display("FAIL hold_no_grant[%0d]: got %b expected %b", c, bus.req_ready, 4'b0000);
            end
            checks++;
            if (bus.rf_read_reg !== 5'd7) begin
                errors++; $display("FAIL hold_select[%0d]: got %0d expected %0d", c, bus.rf_read_reg, 7);
            end
            if (c < 5) step();
        end
        bus.rsp_ready = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++; $display("FAIL hold_next_grant: got %b expected %b", bus.req_ready, 4'b0010);
        end
        step();
        bus.rsp_ready = '0;
        checks++;
        if (bus.rf_read_reg !== 5'd8) begin
            errors++; $display("FAIL hold_next_select: got %0d expected %0d", bus.rf_read_reg, 8);
        end
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL hold_rsp_clear: got %b expected %b", bus.rsp_valid, 4'b0000);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 64'hDEAD_BEEF_0000_0008) begin
            errors++; $display("FAIL hold_next_rsp: got %b/%h expected %b/%h", bus.rsp_valid, bus.rsp_data, 4'b0010, 64'hDEAD_BEEF_0000_0008);
        end
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL hold_third_grant: got %b expected %b", bus.req_ready, 4'b0100);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        bus.req_addr[3] = 5'd10;
        bus.req_valid   = 4'b1000;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++; $display("FAIL midrst_grant: got %b expected %b", bus.req_ready, 4'b1000);
        end
        step();
        checks++;
        if (bus.rf_read_reg !== 5'd10) begin
            errors++; $display("FAIL midrst_select: got %0d expected %0d", bus.rf_read_reg, 10);
        end
        reset           = 1'b1;
        bus.req_addr[1] = 5'd12;
        bus.req_valid   = 4'b1010;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL midrst_rsp_valid: got %b expected %b", bus.rsp_valid, 4'b0000);
        end
        checks++;
        if (bus.rf_read_reg !== 5'd0) begin
            errors++; $display("FAIL midrst_select_clear: got %0d expected %0d", bus.rf_read_reg, 0);
        end
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++; $display("FAIL midrst_lowest_grant: got %b expected %b", bus.req_ready, 4'b0010);
        end
        step();
        bus.req_valid = '0;
        checks++;
        if (bus.rf_read_reg !== 5'd12) begin
            errors++; $display("FAIL midrst_next_select: got %0d expected %0d", bus.rf_read_reg, 12);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 64'hDEAD_BEEF_0000_000C) begin
            errors++; $display("FAIL midrst_next_rsp: got %b/%h expected %b/%h", bus.rsp_valid, bus.rsp_data, 4'b0010, 64'hDEAD_BEEF_0000_000C);
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        // Leave a non-zero value in rsp_data and rf_read_reg=5 first.
        bus.req_addr[2] = 5'd5;
        bus.req_valid   = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL zr_setup_grant: got %b expected %b", bus.req_ready, 4'b0100);
        end
        step();
        bus.req_valid = '0;
        step();
        checks++;
        if (bus.rsp_data !== 64'hDEAD_BEEF_0000_0005) begin
            errors++; $display("FAIL zr_setup_data: got %h expected %h", bus.rsp_data, 64'hDEAD_BEEF_0000_0005);
        end
        bus.rsp_ready = 4'b0100;
        step();
        bus.rsp_ready   = '0;
        bus.req_addr[2] = 5'd31;
        bus.req_valid   = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL zr_grant: got %b expected %b", bus.req_ready, 4'b0100);
        end
        step();
        bus.req_valid = '0;
`ifdef ZERO_REG_BYPASS_EN
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 64'd0) begin
            errors++; $display("FAIL zr_bypass_rsp: got %b/%h expected %b/%h", bus.rsp_valid, bus.rsp_data, 4'b0100, 64'd0);
        end
        checks++;
        if (bus.rf_read_reg !== 5'd5) begin
            errors++; $display("FAIL zr_bypass_select: got %0d expected %0d", bus.rf_read_reg, 5);
        end
`else
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.rf_read_reg !== 5'd31) begin
            errors++; $display("FAIL zr_read_phase: got %b/%0d expected %b/%0d", bus.rsp_valid, bus.rf_read_reg, 4'b0000, 31);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 64'd0) begin
            errors++; $display("FAIL zr_rsp: got %b/%h expected %b/%h", bus.rsp_valid, bus.rsp_data, 4'b0100, 64'd0);
        end
`endif
        bus.rsp_ready = 4'b0100;
        step();
        bus.rsp_ready = '0;
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL zr_rsp_clear: got %b expected %b", bus.rsp_valid, 4'b0000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_hold_and_non_owner();
        test_reset_mid_read();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
